// File: rtl/axi_lite_read_fetcher.sv
// AXI4-Lite read master: fetches N consecutive words into a FWFT FIFO.
// One AR outstanding at a time; AR is only issued when the FIFO has room.
module axi_lite_read_fetcher #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 14,
  parameter int FIFO_DEPTH = 4,
  localparam int PTR_W     = $clog2(FIFO_DEPTH),
  localparam int LVL_W     = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  num_words,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [2:0]        m_axi_arprot,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LVL_W-1:0]  fifo_level
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA
  } state_e;

  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic                push, pop;

  // FIFO bookkeeping: rready is only high in DATA, so push == R beat.
  always_comb begin
    push     = rready_q & m_axi_rvalid;
    pop      = (level_q != '0) & out_ready;
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    unique case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Command sequencing and next-cycle handshake outputs.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    err_d   = err_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_words != '0) begin
            addr_d  = base_addr & ~ADDR_W'(3);
            rem_d   = num_words;
            err_d   = 1'b0;
            state_d = S_ADDR;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_ADDR: begin
        if (arvalid_q && m_axi_arready) state_d = S_DATA;
      end
      S_DATA: begin
        if (m_axi_rvalid) begin
          if (m_axi_rresp != 2'b00) err_d = 1'b1;
          addr_d = addr_q + ADDR_W'(4);
          rem_d  = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ADDR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Once raised, arvalid holds until the handshake moves us to DATA.
    arvalid_d = (state_d == S_ADDR) && (arvalid_q || (level_d < FULL_LVL));
    rready_d  = (state_d == S_DATA);
    busy_d    = (state_d != S_IDLE);
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
    end
  end

  // FIFO storage; contents need no reset since level gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= m_axi_rdata;
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;
  assign out_data      = mem_q[rd_ptr_q];
  assign out_valid     = (level_q != '0);
  assign fifo_level    = level_q;

endmodule

// File: tb/tb_axi_lite_read_fetcher.sv
// Bench for axi_lite_read_fetcher: BRAM slave model plus queue-based
// reference of the expected address/data streams and status flags.
module tb_axi_lite_read_fetcher;

  localparam int AW    = 13;
  localparam int DW    = 32;
  localparam int LW    = 14;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] num_words = '0;
  logic          busy, done, err;
  logic [AW-1:0] araddr;
  logic [2:0]    arprot;
  logic          arvalid;
  logic          arready = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic [1:0]    rresp = '0;
  logic          rvalid = 1'b0;
  logic          rready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [2:0]    fifo_level;

  axi_lite_read_fetcher dut (
    .clk(clk), .reset(reset), .start(start),
    .base_addr(base_addr), .num_words(num_words),
    .busy(busy), .done(done), .err(err),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // slave memory and knobs
  logic [31:0]   mem [0:2047];
  int            hold_next = -1;
  int            ar_max = 3;
  int            r_max = 3;
  int            err_pct = 0;
  bit            use_force = 0;
  logic [1:0]    resp_force = 2'b00;
  bit            rnd_ready = 0;

  // slave state
  bit            ar_pend = 0;
  bit            ar_active = 0;
  logic [AW-1:0] ar_a;
  int            r_cnt = 0;
  int            hold_cnt = 0;

  // reference model
  logic [AW-1:0] exp_addr_q[$];
  logic [31:0]   exp_data_q[$];
  bit            busy_exp = 0;
  bit            done_exp = 0;
  bit            err_exp = 0;
  int            beats_left = 0;
  int            ar_cnt = 0;
  int            done_cnt = 0;
  bit            prev_wait = 0;
  logic [AW-1:0] prev_addr;
  bit            first_chk = 0;

  always @(negedge clk) begin
    if (reset) begin
      arready = 0;
      rvalid = 0;
      ar_pend = 0;
      ar_active = 0;
      hold_cnt = 0;
      exp_addr_q.delete();
      exp_data_q.delete();
      busy_exp = 0;
      done_exp = 0;
      err_exp = 0;
      beats_left = 0;
      prev_wait = 0;
      first_chk = 0;
    end else begin
      bit busy_now;
      busy_now = busy_exp;
      chk("fifo_level", 64'(fifo_level), 64'(exp_data_q.size()));
      chk("out_valid", out_valid, exp_data_q.size() != 0);
      chk("busy", busy, busy_exp);
      chk("done", done, done_exp);
      chk("err", err, err_exp);
      chk("arprot", arprot, 0);
      if (done) done_cnt++;
      if (prev_wait) begin
        chk("arvalid_hold", arvalid, 1);
        chk("araddr_hold", araddr, prev_addr);
      end
      if (first_chk)
        chk("first_arvalid", arvalid, exp_data_q.size() < DEPTH);
      first_chk = 0;
      if (!busy_exp) begin
        chk("idle_arvalid", arvalid, 0);
        chk("idle_rready", rready, 0);
      end
      if (ar_pend) chk("ar_outstanding", arvalid, 0);
      done_exp = 0;
      // consumer pop at the coming edge
      if (out_valid && out_ready) begin
        if (exp_data_q.size() == 0) chk("pop_unexpected", 1, 0);
        else chk("out_data", out_data, exp_data_q.pop_front());
      end
      // R channel: single-cycle rvalid pulse
      rvalid = 0;
      if (ar_pend) begin
        if (r_cnt > 0) r_cnt--;
        else begin
          rvalid = 1;
          rdata = mem[ar_a[12:2]];
          if (use_force) rresp = resp_force;
          else if ($urandom_range(0, 99) < err_pct)
            rresp = 2'($urandom_range(1, 3));
          else rresp = 2'b00;
          chk("rready_at_beat", rready, 1);
          exp_data_q.push_back(rdata);
          if (rresp != 2'b00) err_exp = 1;
          ar_pend = 0;
          beats_left--;
          if (beats_left == 0) begin
            done_exp = 1;
            busy_exp = 0;
          end
        end
      end
      // AR channel
      arready = 0;
      prev_wait = 0;
      if (arvalid) begin
        if (!ar_active) begin
          ar_active = 1;
          hold_cnt = (hold_next >= 0) ? hold_next : $urandom_range(0, ar_max);
        end
        if (hold_cnt > 0) begin
          hold_cnt--;
          prev_wait = 1;
          prev_addr = araddr;
        end else begin
          arready = 1;
          ar_active = 0;
          if (exp_addr_q.size() == 0) chk("ar_unexpected", 1, 0);
          else chk("araddr", araddr, exp_addr_q.pop_front());
          ar_pend = 1;
          ar_a = araddr;
          r_cnt = $urandom_range(0, r_max);
          ar_cnt++;
        end
      end
      // command acceptance at the coming edge
      if (start && !busy_now) begin
        if (num_words == 0) done_exp = 1;
        else begin
          logic [AW-1:0] b;
          b = base_addr & ~13'd3;
          exp_addr_q.delete();
          for (int i = 0; i < int'(num_words); i++)
            exp_addr_q.push_back(b + 13'(4 * i));
          beats_left = int'(num_words);
          busy_exp = 1;
          err_exp = 0;
          first_chk = 1;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic issue(logic [AW-1:0] b, logic [LW-1:0] n);
    start = 1;
    base_addr = b;
    num_words = n;
    cyc();
    start = 0;
  endtask

  task automatic wait_idle(int budget);
    int k = 0;
    while (busy && k < budget) begin
      cyc();
      k++;
    end
    if (busy) chk("timeout_busy", busy, 0);
    cyc();
  endtask

  task automatic drain();
    int k = 0;
    bit r;
    r = rnd_ready;
    rnd_ready = 0;
    out_ready = 1;
    while (fifo_level != 0 && k < 50) begin
      cyc();
      k++;
    end
    if (fifo_level != 0) chk("timeout_drain", 64'(fifo_level), 0);
    cyc();
    rnd_ready = r;
  endtask

  task automatic chk_rst(string t);
    chk({t, "_busy"}, busy, 0);
    chk({t, "_done"}, done, 0);
    chk({t, "_err"}, err, 0);
    chk({t, "_arvalid"}, arvalid, 0);
    chk({t, "_rready"}, rready, 0);
    chk({t, "_out_valid"}, out_valid, 0);
    chk({t, "_araddr"}, araddr, 0);
    chk({t, "_level"}, 64'(fifo_level), 0);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = $urandom;
    repeat (3) @(posedge clk);
    #1;
    chk_rst("rst");
    reset = 0;
    cyc();
    cyc();

    // basic 3-word fetch
    mem[4] = 32'hA0;
    mem[5] = 32'hA1;
    mem[6] = 32'hA2;
    out_ready = 1;
    done_cnt = 0;
    issue(13'h0010, 3);
    wait_idle(200);
    drain();
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_err", err, 0);
    chk("t1_busy", busy, 0);

    // back-pressure: FIFO fills, AR stalls
    out_ready = 0;
    ar_cnt = 0;
    done_cnt = 0;
    issue(13'h0100, 6);
    repeat (40) cyc();
    chk("t2_ar_cnt", ar_cnt, 4);
    chk("t2_arvalid", arvalid, 0);
    chk("t2_level", 64'(fifo_level), 4);
    chk("t2_busy", busy, 1);
    out_ready = 1;
    wait_idle(200);
    drain();
    chk("t2_ar_total", ar_cnt, 6);
    chk("t2_done_cnt", done_cnt, 1);

    // address wrap
    ar_cnt = 0;
    issue(13'h1FFC, 2);
    wait_idle(200);
    drain();
    chk("t3_ar_cnt", ar_cnt, 2);

    // slow arready, one-cycle error beat, sticky err
    hold_next = 5;
    r_max = 0;
    use_force = 1;
    resp_force = 2'b10;
    issue(13'h0040, 1);
    wait_idle(200);
    drain();
    chk("t4_err", err, 1);
    hold_next = -1;
    use_force = 0;
    repeat (5) cyc();
    chk("t4_err_sticky", err, 1);
    issue(13'h0080, 2);
    wait_idle(200);
    drain();
    chk("t4_err_cleared", err, 0);

    // zero-length and start while busy
    ar_cnt = 0;
    done_cnt = 0;
    issue(13'h0200, 0);
    chk("t5_done", done, 1);
    chk("t5_busy", busy, 0);
    cyc();
    chk("t5_done_once", done, 0);
    chk("t5_no_ar", ar_cnt, 0);
    issue(13'h0300, 4);
    cyc();
    start = 1;
    base_addr = 13'h0500;
    num_words = 7;
    cyc();
    cyc();
    start = 0;
    wait_idle(200);
    drain();
    chk("t5_ar_cnt", ar_cnt, 4);
    chk("t5_done_cnt", done_cnt, 2);

    // reset in DATA with two words queued
    begin
      int k = 0;
      r_max = 3;
      out_ready = 0;
      issue(13'h0020, 5);
      while (!(fifo_level == 2 && rready) && k < 200) begin
        cyc();
        k++;
      end
      chk("t6_reach", fifo_level == 2 && rready, 1);
      reset = 1;
      #1;
      chk_rst("t6_rst");
      cyc();
      cyc();
      reset = 0;
      cyc();
      done_cnt = 0;
      out_ready = 1;
      issue(13'h0030, 1);
      wait_idle(200);
      drain();
      chk("t6_done_cnt", done_cnt, 1);
    end

    // randomized commands
    rnd_ready = 1;
    err_pct = 15;
    ar_max = 3;
    for (int it = 0; it < 25; it++) begin
      logic [AW-1:0] b;
      logic [LW-1:0] n;
      b = 13'($urandom);
      if ($urandom_range(0, 1) == 1) b = 13'h1FF0 | 13'($urandom_range(0, 15));
      n = 14'($urandom_range(0, 12));
      done_cnt = 0;
      issue(b, n);
      wait_idle(400);
      drain();
      chk("rnd_done_cnt", done_cnt, 1);
    end
    rnd_ready = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
